// File: rtl/sram_dual_responder.sv
// sram_dual_responder: two-bank async SRAM access FSM; define SRAM_EXTRA_WAIT_EN for one extra wait state per access
module sram_dual_responder #(
  parameter int WR_PULSE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE,
  output logic [17:0] ram_addr1,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data1,
  inout  wire  [15:0] ram_data2,
  output logic        rdn,
  output logic        wrn
);
`ifdef SRAM_EXTRA_WAIT_EN
  localparam bit XW = 1'b1;
`else
  localparam bit XW = 1'b0;
`endif
  localparam logic [1:0] LAST = 2'(WR_PULSE_CYCLES - 1);
  typedef enum logic [3:0] {IDLE, RD_DRIVE, RD_WAIT, RD_SAMPLE, WR_SETUP, WR_WAIT, WR_PULSE, WR_HOLD, DONE} state_t;
  state_t state;
  logic bank;
  logic [1:0] cnt, en_n, oe_n, we_n, drv;
  logic [15:0] wdata;
  logic [17:0] ra [2];
  assign {ram2EN, ram1EN} = en_n;
  assign {ram2OE, ram1OE} = oe_n;
  assign {ram2WE, ram1WE} = we_n;
  assign ram_addr1 = ra[0];
  assign ram_addr2 = ra[1];
  assign ram_data1 = drv[0] ? wdata : 16'bz;
  assign ram_data2 = drv[1] ? wdata : 16'bz;
  assign rdn = 1'b1;
  assign wrn = 1'b1;
  // all SRAM controls are set one edge ahead so they are registered with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bank <= 1'b0;
      cnt <= 2'd0;
      wdata <= 16'h0000;
      data_out <= 16'h0000;
      done <= 1'b0;
      busy <= 1'b0;
      en_n <= 2'b11;
      oe_n <= 2'b11;
      we_n <= 2'b11;
      drv <= 2'b00;
      ra[0] <= 18'd0;
      ra[1] <= 18'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en && (re || we)) begin
          bank <= addr[16];
          wdata <= data_in;
          busy <= 1'b1;
          ra[addr[16]] <= {2'b00, addr[15:0]};
          en_n[addr[16]] <= 1'b0;
          if (we) begin
            drv[addr[16]] <= 1'b1;
            state <= WR_SETUP;
          end else begin
            oe_n[addr[16]] <= 1'b0;
            state <= RD_DRIVE;
          end
        end
        RD_DRIVE: state <= XW ? RD_WAIT : RD_SAMPLE;
        RD_WAIT: state <= RD_SAMPLE;
        RD_SAMPLE: begin
          data_out <= bank ? ram_data2 : ram_data1;
          oe_n <= 2'b11;
          en_n <= 2'b11;
          done <= 1'b1;
          state <= DONE;
        end
        WR_SETUP: begin
          cnt <= 2'd0;
          we_n[bank] <= XW;
          state <= XW ? WR_WAIT : WR_PULSE;
        end
        WR_WAIT: begin
          we_n[bank] <= 1'b0;
          state <= WR_PULSE;
        end
        WR_PULSE: if (cnt == LAST) begin
          we_n <= 2'b11;
          state <= WR_HOLD;
        end else cnt <= cnt + 2'd1;
        WR_HOLD: begin
          drv <= 2'b00;
          en_n <= 2'b11;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_dual_responder.sv
// tb_sram_dual_responder: random and directed accesses against a reference memory and SRAM bank models
module tb_sram_dual_responder;
  localparam int WPC = 2;
`ifdef SRAM_EXTRA_WAIT_EN
  localparam int XW = 1;
`else
  localparam int XW = 0;
`endif
  logic clk, rst, en, re, we, done, busy;
  logic [16:0] addr;
  logic [15:0] data_in, data_out;
  logic ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE, rdn, wrn;
  logic [17:0] ram_addr1, ram_addr2;
  wire [15:0] ram_data1, ram_data2;
  logic [15:0] m1 [65536];
  logic [15:0] m2 [65536];
  logic [15:0] mref [int];
  int checks = 0, errors = 0, bad_strobe = 0;
  sram_dual_responder #(.WR_PULSE_CYCLES(WPC)) dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .busy(busy),
    .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
    .ram2EN(ram2EN), .ram2OE(ram2OE), .ram2WE(ram2WE),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2), .rdn(rdn), .wrn(wrn)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign ram_data1 = (!ram1EN && !ram1OE) ? m1[ram_addr1[15:0]] : 16'bz;
  assign ram_data2 = (!ram2EN && !ram2OE) ? m2[ram_addr2[15:0]] : 16'bz;
  always @(posedge clk) begin
    if (!ram1EN && !ram1WE) m1[ram_addr1[15:0]] <= ram_data1;
    if (!ram2EN && !ram2WE) m2[ram_addr2[15:0]] <= ram_data2;
  end
  always @(negedge clk) if (rdn !== 1'b1 || wrn !== 1'b1) bad_strobe++;
  function automatic logic [15:0] init_val(input logic [16:0] a);
    return a[15:0] ^ (a[16] ? 16'h5A5A : 16'hA5A5);
  endfunction
  function automatic logic [15:0] expect_rd(input logic [16:0] a);
    return mref.exists(int'(a)) ? mref[int'(a)] : init_val(a);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic access(input bit w, input logic [16:0] a, input logic [15:0] d,
                        input bit dual, input bit poke, input bit en_drop);
    int n, wl, oth, bad_busy, bad_bus;
    bit got;
    n = 0; wl = 0; oth = 0; bad_busy = 0; bad_bus = 0; got = 0;
    en = 1'b1; re = !w || dual; we = w; addr = a; data_in = d;
    @(negedge clk);
    re = 1'b0; we = 1'b0; data_in = $urandom;
    if (en_drop) en = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) got = 1; else n++;
      if (!busy) bad_busy++;
      if ((a[16] ? ram2WE : ram1WE) == 1'b0) begin
        wl++;
        if ((a[16] ? ram_data2 : ram_data1) !== d) bad_bus++;
      end
      if ((a[16] ? ram1EN : ram2EN) == 1'b0) oth++;
      if (poke) begin
        re = (k == 1);
        addr = a ^ 17'h00001;
      end
      if (!got) @(negedge clk);
    end
    re = 1'b0;
    chk(w ? "wr_latency" : "rd_latency", n, w ? 2 + WPC + XW : 2 + XW);
    chk("we_low_cycles", wl, w ? WPC : 0);
    chk("other_bank_en", oth, 0);
    chk("busy_during", bad_busy, 0);
    if (w) begin
      chk("wr_bus_data", bad_bus, 0);
      mref[int'(a)] = d;
    end else chk("rd_data", data_out, expect_rd(a));
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
    if (poke) begin
      @(negedge clk);
      chk("poke_ignored", busy, 0);
    end
    en = 1'b1;
  endtask
  initial begin
    logic [16:0] a;
    logic [15:0] d;
    for (int i = 0; i < 65536; i++) begin
      m1[i] = init_val({1'b0, 16'(i)});
      m2[i] = init_val({1'b1, 16'(i)});
    end
    rst = 1'b1; en = 1'b1; re = 1'b1; we = 1'b0; addr = 17'h00003; data_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ctl", {ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 6'h3F);
    chk("rst_addr", {ram_addr1, ram_addr2}, 0);
    re = 1'b0; rst = 1'b0; en = 1'b0; re = 1'b1; we = 1'b1;
    repeat (3) @(negedge clk);
    chk("en0_busy", busy, 0);
    chk("en0_ctl", {ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 6'h3F);
    re = 1'b0; we = 1'b0;
    access(1, 17'h00005, 16'h1234, 0, 0, 0);
    access(0, 17'h00005, 16'h0000, 0, 0, 0);
    chk("wr_rd_1234", data_out, 16'h1234);
    access(1, 17'h10005, 16'hABCD, 0, 0, 0);
    chk("bank2_addr", ram_addr2, 18'h00005);
    chk("bank2_dout_hold", data_out, 16'h1234);
    access(0, 17'h00005, 16'h0000, 0, 1, 0);
    access(1, 17'h00020, 16'h5555, 1, 0, 0);
    access(0, 17'h00020, 16'h0000, 0, 0, 0);
    access(1, 17'h10021, 16'h0F0F, 0, 0, 1);
    access(0, 17'h10021, 16'h0000, 0, 0, 1);
    access(1, 17'h0FFFF, 16'hC0DE, 0, 0, 0);
    access(1, 17'h1FFFF, 16'hBEEF, 0, 0, 0);
    access(0, 17'h0FFFF, 16'h0000, 0, 0, 0);
    access(0, 17'h1FFFF, 16'h0000, 0, 0, 0);
    access(0, 17'h00000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 10; i++) access(1, 17'(i), 16'h0100 + 16'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      access(0, 17'(i), 16'h0000, 0, 0, 0);
      chk("sweep_rd", data_out, 16'h0100 + 16'(i));
    end
    for (int i = 0; i < 40; i++) begin
      a = {1'($urandom), ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15))};
      d = 16'($urandom);
      access(1'($urandom), a, d, 1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 4) == 0));
    end
    en = 1'b1; we = 1'b1; addr = 17'h07777; data_in = 16'h9999;
    @(negedge clk);
    we = 1'b0;
    repeat (1 + XW) @(negedge clk);
    chk("pre_rst_we", ram1WE, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_we", {ram1WE, ram2WE}, 2'b11);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", data_out, 0);
    repeat (4) @(negedge clk);
    chk("mid_rst_nodone", done, 0);
    access(0, 17'h10005, 16'h0000, 0, 0, 0);
    chk("strobes_high", bad_strobe, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
